// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the FIFO family.
package fifo_pkg;

    localparam int  DEF_DATA_W   = 8;
    localparam int  DEF_DEPTH    = 16;
    localparam int  DEF_AE_LEVEL = 2;
    localparam bit  DEF_FWFT     = 1'b0;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered occupancy flags, error pulses and
// selectable registered or first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter bit FWFT     = DEF_FWFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd,
    output logic [DATA_W-1:0]         data_out,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   fifo_cnt,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
    logic [DATA_W-1:0] dout_q, dout_d, rdata;
    logic              rd_acc, wr_acc;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_acc = rd && !empty_q;
    assign wr_acc = wr && (!full_q || rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        dout_d = (rd_acc && !FWFT) ? rdata : dout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == '0);
            full_q   <= (cnt_d == CW'(DEPTH));
            af_q     <= (int'(cnt_d) >= AF_LEVEL);
            ae_q     <= (int'(cnt_d) <= AE_LEVEL);
            ovf_q    <= wr && full_q && !rd_acc;
            unf_q    <= rd && empty_q;
            dout_q   <= dout_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // FWFT output depends only on registered pointers/flags, never on wr/rd directly.
    generate
        if (FWFT) begin : g_fwft
            assign data_out = empty_q ? '0 : rdata;
        end else begin : g_reg
            assign data_out = dout_q;
        end
    endgenerate

    assign empty        = empty_q;
    assign full         = full_q;
    assign fifo_cnt     = cnt_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: table-driven vectors on a registered-read
// instance with a data scoreboard, plus hand sequences for FWFT and reset.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    logic [DW-1:0] din0 = 0, din1 = 0, dout0, dout1;
    logic          emp0, ful0, af0, ae0, ovf0, unf0;
    logic          emp1, ful1, af1, ae1, ovf1, unf1;
    logic [3:0]    cnt0, cnt1;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr(wr0), .data_in(din0), .rd(rd0), .data_out(dout0),
        .empty(emp0), .full(ful0), .fifo_cnt(cnt0), .almost_full(af0),
        .almost_empty(ae0), .overflow(ovf0), .underflow(unf0));

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr(wr1), .data_in(din1), .rd(rd1), .data_out(dout1),
        .empty(emp1), .full(ful1), .fifo_cnt(cnt1), .almost_full(af1),
        .almost_empty(ae1), .overflow(ovf1), .underflow(unf1));

    typedef struct {
        bit          w;
        bit          r;
        logic [7:0]  d;
        int          cnt;
        bit          ovf;
        bit          unf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_dout;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    endtask

    function automatic void add(bit w, bit r, logic [7:0] d, int cnt, bit ovf, bit unf);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_cnt0"},  32'(cnt0), 0);
        chk({tag, "_emp0"},  32'(emp0), 1);
        chk({tag, "_ful0"},  32'(ful0), 0);
        chk({tag, "_ae0"},   32'(ae0),  1);
        chk({tag, "_af0"},   32'(af0),  0);
        chk({tag, "_ovf0"},  32'(ovf0), 0);
        chk({tag, "_unf0"},  32'(unf0), 0);
        chk({tag, "_dout0"}, 32'(dout0), 0);
        chk({tag, "_cnt1"},  32'(cnt1), 0);
        chk({tag, "_emp1"},  32'(emp1), 1);
        chk({tag, "_dout1"}, 32'(dout1), 0);
    endtask

    initial begin
        // write 42 then read it back
        add(1, 0, 8'd42, 1, 0, 0);
        add(0, 1, 8'd0,  0, 0, 0);
        // fill, overflow with 99, drain
        for (int i = 1; i <= 8; i++) add(1, 0, 8'(i), i, 0, 0);
        add(1, 0, 8'd99, 8, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 8'd0, 8 - i, 0, 0);
        // pointer wrap: 8 in, 5 out, 10..14 in, drain
        for (int i = 1; i <= 8; i++) add(1, 0, 8'(i), i, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 8'd0, 8 - i, 0, 0);
        for (int i = 0; i < 5; i++)  add(1, 0, 8'(10 + i), 4 + i, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 8'd0, 8 - i, 0, 0);
        // full with simultaneous wr+rd, then underflow cases
        for (int i = 0; i < 8; i++)  add(1, 0, 8'(20 + i), i + 1, 0, 0);
        add(1, 1, 8'd77, 8, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 8'd0, 8 - i, 0, 0);
        add(0, 1, 8'd0, 0, 0, 1);
        add(1, 1, 8'd5, 1, 0, 1);
        add(0, 1, 8'd0, 0, 0, 0);

        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1;
        model_dout = 8'd0;

        foreach (vecs[k]) begin
            bit ra, wa;
            ra = vecs[k].r && (mq.size() > 0);
            wa = vecs[k].w && (mq.size() < DP || ra);
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(vecs[k].d);
            wr0 = vecs[k].w; rd0 = vecs[k].r; din0 = vecs[k].d;
            tick();
            if (exp_q.size() > 0) model_dout = exp_q.pop_front();
            chk($sformatf("v%0d_cnt", k),   32'(cnt0), vecs[k].cnt);
            chk($sformatf("v%0d_empty", k), 32'(emp0), 32'(vecs[k].cnt == 0));
            chk($sformatf("v%0d_full", k),  32'(ful0), 32'(vecs[k].cnt == DP));
            chk($sformatf("v%0d_af", k),    32'(af0),  32'(vecs[k].cnt >= 6));
            chk($sformatf("v%0d_ae", k),    32'(ae0),  32'(vecs[k].cnt <= 2));
            chk($sformatf("v%0d_ovf", k),   32'(ovf0), 32'(vecs[k].ovf));
            chk($sformatf("v%0d_unf", k),   32'(unf0), 32'(vecs[k].unf));
            chk($sformatf("v%0d_dout", k),  32'(dout0), 32'(model_dout));
        end

        // first-word-fall-through instance
        wr1 = 1; din1 = 8'd30; tick();
        chk("fwft_w30_dout", 32'(dout1), 30);
        chk("fwft_w30_emp",  32'(emp1), 0);
        chk("fwft_w30_cnt",  32'(cnt1), 1);
        wr1 = 1; din1 = 8'd55; tick();
        chk("fwft_w55_dout", 32'(dout1), 30);
        chk("fwft_w55_cnt",  32'(cnt1), 2);
        rd1 = 1; tick();
        chk("fwft_rd_dout",  32'(dout1), 55);
        chk("fwft_rd_cnt",   32'(cnt1), 1);
        rd1 = 1; tick();
        chk("fwft_rd2_emp",  32'(emp1), 1);
        rd1 = 1; tick();
        chk("fwft_unf",      32'(unf1), 1);

        // mid-operation reset with wr/rd asserted
        for (int i = 0; i < 5; i++) begin
            wr0 = 1; din0 = 8'(60 + i); wr1 = 1; din1 = 8'(60 + i);
            tick();
        end
        chk("pre_rst_cnt0", 32'(cnt0), 5);
        chk("pre_rst_cnt1", 32'(cnt1), 5);
        rst = 0; wr0 = 1; rd0 = 1; din0 = 8'hAA; wr1 = 1; rd1 = 1; din1 = 8'hAA;
        tick();
        rst = 1;
        chk_reset("mid");
        wr0 = 1; din0 = 8'd87; wr1 = 1; din1 = 8'd87; tick();
        chk("post_rst_fwft_dout", 32'(dout1), 87);
        chk("post_rst_cnt0",      32'(cnt0), 1);
        rd0 = 1; tick();
        chk("post_rst_dout0",     32'(dout0), 87);
        chk("post_rst_emp0",      32'(emp0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
